// File: rtl/dmem_dual_port_sched_pkg.sv
// Shared definitions for the dual-lane data-memory scheduler.
//   state_t   : scheduler FSM encoding
//   LANE0/1   : lane identifiers used for mux select and read-return tag
//   WORD_LSB  : byte-address bits dropped when forming the word address
package dmem_dual_port_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int WORD_LSB = 2;

endpackage

// File: rtl/dmem_req_mux.sv
// Combinational lane selector onto the data-memory request port.
// Ports:
//   sel                     lane select (LANE0/LANE1)
//   en                      access strobe for this cycle
//   we0/waddr0/wdata0       lane 0 request fields (word address)
//   we1/waddr1/wdata1       lane 1 request fields (word address)
//   mem_en/mem_we/mem_addr/mem_wdata   memory request outputs
module dmem_req_mux
  import dmem_dual_port_sched_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              en,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    mem_en    = en;
    mem_we    = 1'b0;
    mem_addr  = waddr0;
    mem_wdata = wdata0;
    if (sel == LANE1) begin
      mem_we    = en & we1;
      mem_addr  = waddr1;
      mem_wdata = wdata1;
    end else begin
      mem_we    = en & we0;
    end
  end

endmodule

// File: rtl/dmem_dual_port_sched.sv
// Schedules two MEM-stage lanes onto a single-ported, synchronous-read
// data memory. A bundle where both lanes access memory is split over two
// cycles in program order (lane 0 first) and stalls the pipeline once.
//
// state  | meaning
// IDLE   | accepting a new bundle; lane 0 or a lone lane 1 goes to memory
// SECOND | second half of a conflicting bundle; lane 1 goes to memory
//
// Ports:
//   CLK, CLR                 clock, async active-high reset
//   req/we/addr/wdata 0,1    lane requests (byte addresses)
//   bundle_stall             freezes both lanes and upstream
//   rdata0/1, rvalid0/1      sticky load results and 1-cycle update pulses
//   mem_en/we/addr/wdata     memory request port
//   mem_rdata                memory read data, one cycle after a read
//   conflict_cnt             saturating count of conflict stalls
module dmem_dual_port_sched
  import dmem_dual_port_sched_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              bundle_stall,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  state_t state_q, state_d;
  logic   sel;
  logic   acc_en;
  logic   conflict_inc;
  logic   tag_vld_q;
  logic   tag_lane_q;

  logic [ADDR_W-1:0] waddr0, waddr1;
  logic              unused_addr_bits;

  assign waddr0 = addr0[ADDR_W+WORD_LSB-1:WORD_LSB];
  assign waddr1 = addr1[ADDR_W+WORD_LSB-1:WORD_LSB];

  // Byte offset and address bits beyond the memory size are don't-care.
  assign unused_addr_bits = ^{addr0[31:ADDR_W+WORD_LSB], addr0[WORD_LSB-1:0],
                              addr1[31:ADDR_W+WORD_LSB], addr1[WORD_LSB-1:0]};

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Outputs are forced idle while CLR is high so the stall and any pending
  // lane 1 access disappear immediately, not at the next edge.
  always_comb begin
    state_d      = state_q;
    sel          = LANE0;
    acc_en       = 1'b0;
    bundle_stall = 1'b0;
    conflict_inc = 1'b0;
    if (!CLR) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req0 && req1) begin
            acc_en       = 1'b1;
            sel          = LANE0;
            bundle_stall = 1'b1;
            conflict_inc = 1'b1;
            state_d      = ST_SECOND;
          end else if (req0) begin
            acc_en = 1'b1;
            sel    = LANE0;
          end else if (req1) begin
            acc_en = 1'b1;
            sel    = LANE1;
          end
        end
        ST_SECOND: begin
          // Lanes are frozen by the stall, so their inputs are still valid.
          acc_en  = 1'b1;
          sel     = LANE1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  dmem_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel       (sel),
    .en        (acc_en),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Single-entry read tag: a read issued this cycle returns data next cycle,
  // which is captured at the end of that cycle. Reads can occur every cycle,
  // so the tag is simply overwritten each cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      tag_vld_q  <= 1'b0;
      tag_lane_q <= LANE0;
      rdata0     <= '0;
      rdata1     <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      tag_vld_q  <= mem_en & ~mem_we;
      tag_lane_q <= sel;
      rvalid0    <= tag_vld_q && (tag_lane_q == LANE0);
      rvalid1    <= tag_vld_q && (tag_lane_q == LANE1);
      if (tag_vld_q && (tag_lane_q == LANE0)) rdata0 <= mem_rdata;
      if (tag_vld_q && (tag_lane_q == LANE1)) rdata1 <= mem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      conflict_cnt <= '0;
    end else if (conflict_inc && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_dmem_dual_port_sched.sv
module tb_dmem_dual_port_sched;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        bundle_stall, rvalid0, rvalid1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_wdata, conflict_cnt;
  logic [31:0] mem_rdata = '0;
  logic [9:0]  mem_addr;

  logic        s_stall, s_rv0, s_rv1, s_en, s_we;
  logic [31:0] s_rd0, s_rd1, s_wdata;
  logic [9:0]  s_addr;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  dmem_dual_port_sched #(.ADDR_W(10), .DATA_W(32), .CNT_W(32)) dut (
    .CLK(clk), .CLR(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .bundle_stall(bundle_stall), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  dmem_dual_port_sched #(.ADDR_W(10), .DATA_W(32), .CNT_W(3)) dut_sat (
    .CLK(clk), .CLR(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .bundle_stall(s_stall), .rdata0(s_rd0), .rdata1(s_rd1),
    .rvalid0(s_rv0), .rvalid1(s_rv1),
    .mem_en(s_en), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(s_cnt)
  );

  // Data memory driven by the main instance.
  logic [31:0] ram  [1024];
  // Reference memory contents in program order.
  logic [31:0] mmem [1024];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Per-cycle expectations built by the stimulus from the scheduling rules.
  bit          exp_valid [MAXC];
  bit          exp_stall [MAXC];
  bit          exp_en    [MAXC];
  bit          exp_we    [MAXC];
  logic [9:0]  exp_addr  [MAXC];
  logic [31:0] exp_wdata [MAXC];
  bit          exp_rv0   [MAXC];
  bit          exp_rv1   [MAXC];
  logic [31:0] exp_rd0   [MAXC];
  logic [31:0] exp_rd1   [MAXC];

  int          cyc = 0;
  bit          chk_on = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_rd0 = '0, m_rd1 = '0;
  longint      m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && exp_valid[cyc]) begin
      check("bundle_stall", 32'(bundle_stall), 32'(exp_stall[cyc]));
      check("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
      if (exp_en[cyc]) begin
        check("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
        if (exp_we[cyc]) check("mem_wdata", mem_wdata, exp_wdata[cyc]);
      end
      if (exp_rv0[cyc]) m_rd0 = exp_rd0[cyc];
      if (exp_rv1[cyc]) m_rd1 = exp_rd1[cyc];
      check("rvalid0", 32'(rvalid0), 32'(exp_rv0[cyc]));
      check("rvalid1", 32'(rvalid1), 32'(exp_rv1[cyc]));
      check("rdata0", rdata0, m_rd0);
      check("rdata1", rdata1, m_rd1);
      check("conflict_cnt", conflict_cnt, m_cnt[31:0]);
      check("sat_cnt", 32'(s_cnt), (m_cnt > 7) ? 32'd7 : m_cnt[31:0]);
      check("sat_stall", 32'(s_stall), 32'(exp_stall[cyc]));
      if (exp_stall[cyc]) m_cnt++;
    end
  end

  task automatic access(input int c, input bit lane, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    int word;
    word = int'((a >> 2) % 1024);
    exp_en[c]    = 1'b1;
    exp_we[c]    = w;
    exp_addr[c]  = word[9:0];
    exp_wdata[c] = d;
    if (w) mmem[word] = d;
    else if (!lane) begin exp_rv0[c+2] = 1'b1; exp_rd0[c+2] = mmem[word]; end
    else            begin exp_rv1[c+2] = 1'b1; exp_rd1[c+2] = mmem[word]; end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    exp_valid[cyc] = 1'b1;
  endtask

  task automatic issue(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    next_cycle();
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (r0 && r1) begin
      exp_stall[cyc] = 1'b1;
      access(cyc, 1'b0, w0, a0, d0);
      next_cycle();
      access(cyc, 1'b1, w1, a1, d1);
    end else if (r0) begin
      access(cyc, 1'b0, w0, a0, d0);
    end else if (r1) begin
      access(cyc, 1'b1, w1, a1, d1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int          w;
    a = $urandom;
    w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15));
    a[11:2] = w[9:0];
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = $urandom;
      mmem[i] = ram[i];
    end
    ram[4] = 32'hA; mmem[4] = 32'hA;
    ram[5] = 32'hB; mmem[5] = 32'hB;

    // Reset state with both requests asserted.
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
    #12;
    check("rst_stall", 32'(bundle_stall), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_cnt", conflict_cnt, 32'd0);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    rst = 0;
    cyc = 0;
    exp_valid[0] = 1'b1;
    chk_on = 1'b1;

    // Lane 0 store then lane 1 load of the same word.
    issue(1, 1, 32'h80, 32'hDEADBEEF, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 0, 32'h80, 0);
    idle(3);
    check("t1_rdata1", rdata1, 32'hDEADBEEF);

    // Same-bundle store/load conflict.
    issue(1, 1, 32'h40, 32'h11111111, 1, 0, 32'h40, 0);
    idle(3);
    check("t2_rdata1", rdata1, 32'h11111111);
    check("t2_cnt", conflict_cnt, 32'd1);

    // Dual loads in one bundle.
    issue(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
    idle(4);
    check("t3_rdata0", rdata0, 32'hA);
    check("t3_rdata1", rdata1, 32'hB);

    // Write-write conflict.
    issue(1, 1, 32'h0, 32'h1, 1, 1, 32'h0, 32'h2);
    idle(2);
    check("t4_mem0", ram[0], 32'h2);
    check("t4_cnt", conflict_cnt, 32'd3);

    // Randomized bundles.
    for (int n = 0; n < 400; n++) begin
      bit r0, r1;
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      issue(r0, 1'($urandom), rand_addr(), $urandom,
            r1, 1'($urandom), rand_addr(), $urandom);
    end
    idle(4);
    check("sat_final", 32'(s_cnt), 32'd7);
    @(posedge clk); #1;
    chk_on = 1'b0;

    // Reset during a conflict cycle drops the stall immediately.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    #2;
    check("clr_pre_stall", 32'(bundle_stall), 32'd1);
    rst = 1;
    #2;
    check("clr_idle_stall", 32'(bundle_stall), 32'd0);
    check("clr_idle_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("clr_restart_stall", 32'(bundle_stall), 32'd1);

    // Reset during the second half, with the lane 0 load in flight.
    @(posedge clk); #1;
    check("second_en", 32'(mem_en), 32'd1);
    check("second_addr", 32'(mem_addr), 32'd5);
    check("second_cnt", conflict_cnt, 32'd1);
    rst = 1;
    #2;
    check("clr2_stall", 32'(bundle_stall), 32'd0);
    check("clr2_en", 32'(mem_en), 32'd0);
    check("clr2_cnt", conflict_cnt, 32'd0);
    check("clr2_rdata0", rdata0, 32'd0);
    check("clr2_rdata1", rdata1, 32'd0);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      check("post_rvalid0", 32'(rvalid0), 32'd0);
      check("post_rvalid1", 32'(rvalid1), 32'd0);
      check("post_en", 32'(mem_en), 32'd0);
      @(posedge clk); #1;
    end
    check("post_rdata0", rdata0, 32'd0);
    check("post_cnt", conflict_cnt, 32'd0);
    check("post_sat_cnt", 32'(s_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_dual_port_sched.md
Name: dmem_dual_port_sched

Overview:
- Schedules the two superscalar lanes' load/store requests onto the single-ported, synchronous-read data memory.
- When both lanes of an issue bundle access memory in the same cycle, the block serialises them in program order (lane 0 older) and stalls the bundle for one cycle.
- Sits between the two MEM-stage lanes of the phase-4 core and the data memory instance.

Parameters:
- ADDR_W, 10, word-address width driven to the memory (1024 words).
- DATA_W, 32, data width.
- CNT_W, 32, width of the conflict-stall performance counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- req0  in  1  lane 0 memory access request.
- we0  in  1  lane 0 write enable (1 = store, 0 = load).
- addr0  in  32  lane 0 byte address; bits [1:0] ignored.
- wdata0  in  DATA_W  lane 0 store data.
- req1, we1, addr1, wdata1  in  1/1/32/DATA_W  lane 1 equivalents.
- bundle_stall  out  1  freezes both lanes and the upstream pipeline.
- rdata0  out  DATA_W  last lane 0 load result (sticky register).
- rdata1  out  DATA_W  last lane 1 load result (sticky register).
- rvalid0  out  1  1-cycle pulse when rdata0 has just been updated.
- rvalid1  out  1  1-cycle pulse when rdata1 has just been updated.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address, equal to addrK[ADDR_W+1:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.
- conflict_cnt  out  CNT_W  count of conflict stalls; saturates at all-ones.

Behaviour:
- Reset values (asynchronous): FSM=IDLE; rdata0=rdata1=0; rvalid0=rvalid1=0; conflict_cnt=0; pending-read tag cleared.
- Reset output levels: bundle_stall=0, mem_en=0.
- FSM has two states, IDLE and SECOND.
- IDLE, no request: mem_en=0, bundle_stall=0.
- IDLE, exactly one reqK: drive lane K to memory combinationally (mem_en=1, mem_we=weK, mem_addr, mem_wdata); bundle_stall=0; stay in IDLE.
- IDLE, req0 and req1 both high: drive lane 0; bundle_stall=1; conflict_cnt += 1 (saturating); next state SECOND.
- SECOND: drive lane 1; bundle_stall=0; req0/req1 are ignored, because lanes hold their inputs stable during a stall. Next state IDLE.
- Ordering rule: lane 0 is always accessed first, so lane0-store/lane1-load to the same address returns the stored value. No round-robin.
- Read return: a load issued in cycle c sets a registered tag (lane ID, valid).
  - In cycle c+1, mem_rdata is captured into rdataK at the edge ending c+1.
  - rvalidK is high during cycle c+2, and rdataK holds its value until the next lane K load completes.
  - Load-to-rdata latency is 2 cycles.
- Stores produce no rvalid pulse.
- Back-to-back loads on alternating lanes in consecutive cycles are legal; the tag is a single register updated every cycle.
- Write-write conflict to the same address: lane 1 data remains in memory (program order).
- Reset asserted while in SECOND: FSM goes to IDLE immediately, the lane 1 access is dropped, and bundle_stall goes low asynchronously.
- Reset asserted with a read in flight: the tag is cleared, no rvalid pulse occurs, and rdata is zeroed.
- bundle_stall is a combinational function of state and requests. It never asserts for two consecutive cycles from a single bundle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, SECOND=1'b1);
  - lane ID constants LANE0/LANE1;
  - the word-address slice helper width constant.
- One sub-module, dmem_req_mux: purely combinational selection of lane fields onto the mem_* outputs, given a lane-select bit.
- FSM, read tag, rdata registers and counter live in the top.

Test Plan:
- Single lane 0 store, addr0=0x80, wdata0=0xDEADBEEF, followed by a lane 1 load of addr1=0x80 in the next cycle. Required: bundle_stall never high; mem_addr=0x20 both cycles; rdata1=0xDEADBEEF with rvalid1 high two cycles after the load.
- Same-bundle conflict: lane0 store 0x11111111 @0x40 and lane1 load @0x40. Required: bundle_stall=1 for exactly one cycle; lane 0 access first, then lane 1; rdata1=0x11111111; conflict_cnt=1.
- Dual loads in one bundle, mem[0x10]=0xA, mem[0x14]=0xB. Required: rdata0=0xA valid at cycle+2, rdata1=0xB valid at cycle+3; both values remain sticky afterwards.
- Write-write conflict, both lanes store to @0x0 with 0x1 (lane0) and 0x2 (lane1). Required: final mem[0]=0x2.
- CLR asserted in SECOND. Required: bundle_stall drops without waiting for a clock edge; no lane 1 memory access; rvalid0/1=0; conflict_cnt=0.
- Saturation: force 2^CNT_W conflicts with CNT_W overridden to 3. Required: conflict_cnt stops at 7.
